dp_sequencer: RTL and testbench

Multi-cycle control FSM that sequences one ARM data-processing instruction at a time through the shared RegisterFile / BarrelShifter / ARM_ALU datapath. It accepts an instruction word on a start/done handshake and evaluates the condition field against the live ALU flags. It drives the register-select, ALU-op and load strobes so the result is written to Rd, or to the PC when Rd = 15. It sits between the instruction-fetch logic and the datapath, and is the only block that drives RSLCT, LOAD, LOADPC, OP, S and ALU_OUT.

---
 rtl/dp_sequencer_if.sv | 30 +++
 rtl/dp_sequencer.sv | 179 +++++++++++++++++
 tb/tb_dp_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dp_sequencer_if.sv
// Handshake and datapath-control bundle between fetch logic, dp_sequencer and the datapath.
interface dp_sequencer_if;
  logic        start;
  logic [31:0] IR_in;
  logic [3:0]  FLAGS;
  logic        busy;
  logic        done;
  logic        skipped;
  logic        illegal;
  logic [31:0] IR;
  logic [19:0] RSLCT;
  logic        LOAD;
  logic        LOADPC;
  logic        IR_CU;
  logic [4:0]  OP;
  logic        S;
  logic        ALU_OUT;

  // Requesting side: fetch logic / datapath flags
  modport master (
    output start, IR_in, FLAGS,
    input  busy, done, skipped, illegal, IR, RSLCT, LOAD, LOADPC, IR_CU, OP, S, ALU_OUT
  );

  // Sequencer side
  modport slave (
    input  start, IR_in, FLAGS,
    output busy, done, skipped, illegal, IR, RSLCT, LOAD, LOADPC, IR_CU, OP, S, ALU_OUT
  );
endinterface

// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer for one ARM data-processing instruction at a time.
module dp_sequencer (
  input logic           Clk,
  input logic           RESET,
  dp_sequencer_if.slave bus
);

  localparam int unsigned IR_W    = 32;
  localparam int unsigned RSLCT_W = 20;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 4;

  localparam logic [OP_W-1:0]  OP_IDLE = 5'd17;
  localparam logic [REG_W-1:0] PC_REG  = 4'd15;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    COND = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Fields of the latched instruction
  logic [3:0]       cond_f;
  logic [3:0]       opc_f;
  logic             sbit_f;
  logic [REG_W-1:0] rn_f, rd_f, rs_f, rm_f;

  assign cond_f = bus.IR[31:28];
  assign opc_f  = bus.IR[24:21];
  assign sbit_f = bus.IR[20];
  assign rn_f   = bus.IR[19:16];
  assign rd_f   = bus.IR[15:12];
  assign rs_f   = bus.IR[11:8];
  assign rm_f   = bus.IR[3:0];

  // Register selects come from this block at all times
  assign bus.IR_CU = 1'b1;

  logic illegal_c;
  logic pass_c;
  logic compare_c;

  // ARM condition-code evaluation against {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = ~c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = c & ~z;
      4'h9:    cond_pass = ~c | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign illegal_c = (bus.IR[27:26] != 2'b00);
  assign pass_c    = cond_pass(cond_f, bus.FLAGS);
  // TST/TEQ/CMP/CMN only update flags
  assign compare_c = (opc_f[3:2] == 2'b10);

  // State register
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = COND;
      COND:    state_d = (illegal_c || !pass_c) ? DONE : EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the state being entered; registered below
  logic                busy_d, done_d, skipped_d, illegal_d;
  logic [IR_W-1:0]     ir_d;
  logic [RSLCT_W-1:0]  rslct_d;
  logic                load_d, loadpc_d, s_d, alu_out_d;
  logic [OP_W-1:0]     op_d;

  // Output decode
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    skipped_d = 1'b0;
    illegal_d = 1'b0;
    ir_d      = '0;
    rslct_d   = '0;
    load_d    = 1'b0;
    loadpc_d  = 1'b0;
    op_d      = OP_IDLE;
    s_d       = 1'b0;
    alu_out_d = 1'b0;
    case (state_d)
      COND: begin
        busy_d = 1'b1;
        ir_d   = bus.IR_in;
      end
      EXEC, WB: begin
        busy_d    = 1'b1;
        ir_d      = bus.IR;
        rslct_d   = {rn_f, rd_f, rs_f, rm_f, rn_f};
        op_d      = {1'b0, opc_f};
        alu_out_d = 1'b1;
        if (state_d == WB) begin
          if (compare_c) begin
            s_d = 1'b1;
          end else begin
            s_d = sbit_f;
            if (rd_f == PC_REG) loadpc_d = 1'b1;
            else                load_d   = 1'b1;
          end
        end
      end
      DONE: begin
        busy_d    = 1'b1;
        done_d    = 1'b1;
        ir_d      = bus.IR;
        illegal_d = (state_q == COND) && illegal_c;
        skipped_d = (state_q == COND) && !illegal_c && !pass_c;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.skipped <= 1'b0;
      bus.illegal <= 1'b0;
      bus.IR      <= '0;
      bus.RSLCT   <= '0;
      bus.LOAD    <= 1'b0;
      bus.LOADPC  <= 1'b0;
      bus.OP      <= OP_IDLE;
      bus.S       <= 1'b0;
      bus.ALU_OUT <= 1'b0;
    end else begin
      bus.busy    <= busy_d;
      bus.done    <= done_d;
      bus.skipped <= skipped_d;
      bus.illegal <= illegal_d;
      bus.IR      <= ir_d;
      bus.RSLCT   <= rslct_d;
      bus.LOAD    <= load_d;
      bus.LOADPC  <= loadpc_d;
      bus.OP      <= op_d;
      bus.S       <= s_d;
      bus.ALU_OUT <= alu_out_d;
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer with hand-computed expectations.
module tb_dp_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  dp_sequencer_if bus_if ();

  dp_sequencer dut (
    .Clk   (clk),
    .RESET (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one instruction and check every cycle until busy drops.
  // wr: 0 none, 1 LOAD, 2 LOADPC
  task automatic run_instr(input logic [31:0] ir, input logic [3:0] flags,
                           input int n, input int wr, input logic exp_skip,
                           input logic exp_ill, input logic [19:0] exp_rslct,
                           input logic [4:0] exp_op, input logic exp_s);
    bus_if.start = 1'b1;
    bus_if.IR_in = ir;
    bus_if.FLAGS = flags;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      chk("busy", bus_if.busy, 1'b1);
      chk("done", bus_if.done, (c == n));
      chk("load", bus_if.LOAD, (n == 4 && c == 3 && wr == 1));
      chk("loadpc", bus_if.LOADPC, (n == 4 && c == 3 && wr == 2));
      if (c == 1) chk("ir_latch", bus_if.IR, ir);
      if (n == 4 && (c == 2 || c == 3)) begin
        chk("rslct", bus_if.RSLCT, exp_rslct);
        chk("op", bus_if.OP, exp_op);
        chk("alu_out", bus_if.ALU_OUT, 1'b1);
        chk("s", bus_if.S, (c == 3) ? exp_s : 1'b0);
      end
      if (c == n) begin
        chk("skipped", bus_if.skipped, exp_skip);
        chk("illegal", bus_if.illegal, exp_ill);
        chk("op_done", bus_if.OP, 5'd17);
        chk("alu_out_done", bus_if.ALU_OUT, 1'b0);
      end
    end
    @(negedge clk);
    chk("busy_end", bus_if.busy, 1'b0);
    chk("done_end", bus_if.done, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus_if.start = 1'b0;
    bus_if.IR_in = 32'h0;
    bus_if.FLAGS = 4'h0;
    rst_n = 1'b0;
    #12;
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_op", bus_if.OP, 5'd17);
    chk("rst_ircu", bus_if.IR_CU, 1'b1);
    chk("rst_ir", bus_if.IR, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no start: reset values hold
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_busy", bus_if.busy, 1'b0);
      chk("idle_op", bus_if.OP, 5'd17);
      chk("idle_rslct", bus_if.RSLCT, 20'h0);
      chk("idle_load", {bus_if.LOAD, bus_if.LOADPC, bus_if.done, bus_if.S, bus_if.ALU_OUT}, 5'b0);
    end

    // ADD R2,R1,R3 (AL)
    run_instr(32'hE0812003, 4'h0, 4, 1, 1'b0, 1'b0, 20'h12031, 5'd4, 1'b0);
    // ADDEQ R15,R1,R3 with Z=1 -> PC write
    run_instr(32'h0081F003, 4'b0100, 4, 2, 1'b0, 1'b0, 20'h1F031, 5'd4, 1'b0);
    // ADDEQ with Z=0 -> skipped
    run_instr(32'h0081F003, 4'b0000, 2, 0, 1'b1, 1'b0, 20'h0, 5'd17, 1'b0);
    // CMP R1,R2 -> flags only
    run_instr(32'hE1510002, 4'h0, 4, 0, 1'b0, 1'b0, 20'h10021, 5'd10, 1'b1);
    // ADDLT R2,R1,R3 with N=1,V=0 -> pass; N=1,V=1 -> fail
    run_instr(32'hB0812003, 4'b1000, 4, 1, 1'b0, 1'b0, 20'h12031, 5'd4, 1'b0);
    run_instr(32'hB0812003, 4'b1001, 2, 0, 1'b1, 1'b0, 20'h0, 5'd17, 1'b0);
    // Non data-processing class -> illegal
    run_instr(32'hEC000000, 4'h0, 2, 0, 1'b0, 1'b1, 20'h0, 5'd17, 1'b0);

    // Reset during WB of an ADD
    bus_if.start = 1'b1;
    bus_if.IR_in = 32'hE0812003;
    bus_if.FLAGS = 4'h0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
    end
    chk("wb_load_pre", bus_if.LOAD, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_load", bus_if.LOAD, 1'b0);
    chk("abort_busy", bus_if.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_done", bus_if.done, 1'b0);
      chk("abort_idle", bus_if.busy, 1'b0);
    end
    run_instr(32'hE0812003, 4'h0, 4, 1, 1'b0, 1'b0, 20'h12031, 5'd4, 1'b0);

    // start held high across three ADDs
    bus_if.start = 1'b1;
    bus_if.IR_in = 32'hE0812003;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 15) bus_if.start = 1'b0;
      chk("hold_done", bus_if.done, (c == 4 || c == 9 || c == 14));
      chk("hold_busy", bus_if.busy, !(c == 5 || c == 10 || c == 15));
      chk("hold_load", bus_if.LOAD, (c == 3 || c == 8 || c == 13));
    end
    @(negedge clk);
    chk("hold_end_busy", bus_if.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
